// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;
    localparam int          CNT_W_DEF       = 32;
    localparam logic [31:0] DEFAULT_DIV_DEF = 32'hC350;
    localparam int          MAX_CH          = 16;

    // Channel-select width; a single-channel build still needs a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clock_divider_mc_ch.sv
// One divider channel: counter, active/pending divisor, 50% toggle and Tick strobe.
module clock_divider_ch
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic             sync_i,
    output logic             div_clk_o,
    output logic             tick_o
);
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] next_div;
    logic             div_q, div_d;
    logic             tick_q, tick_d;

    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        count_d   = count_q;
        div_d     = div_q;
        tick_d    = 1'b0;
        next_div  = pending_q;
        if (active_q == '0) begin
            // Disabled channel: a write starts it straight away from a clean phase.
            if (load_i) begin
                active_d  = wr_data_i;
                pending_d = wr_data_i;
            end
            count_d = '0;
            div_d   = 1'b0;
        end else if (sync_i) begin
            if (load_i)
                pending_d = wr_data_i;
            active_d = pending_q;
            count_d  = '0;
            div_d    = 1'b0;
        end else begin
            if (load_i)
                pending_d = wr_data_i;
            if (count_q == active_q) begin
                // A write landing on the wrap cycle supersedes the older pending value.
                next_div = load_i ? wr_data_i : pending_q;
                active_d = next_div;
                count_d  = '0;
                if (next_div == '0) begin
                    div_d = 1'b0;
                end else begin
                    div_d  = ~div_q;
                    tick_d = 1'b1;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            active_q  <= DEFAULT_DIV;
            pending_q <= DEFAULT_DIV;
            count_q   <= '0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
        end
    end

    assign div_clk_o = div_q;
    assign tick_o    = tick_q;
endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider with per-channel runtime divisors.
// Define CLKDIV_PHASE_SYNC_EN to add the Sync input that realigns all enabled channels.
module clock_divider_mc
    import clkdiv_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          WrEn,
    input  logic [ch_idx_w(NUM_CH)-1:0]   WrCh,
    input  logic [CNT_W-1:0]              WrData,
    output logic [NUM_CH-1:0]             DividedClock,
    output logic [NUM_CH-1:0]             Tick
`ifdef CLKDIV_PHASE_SYNC_EN
    ,
    input  logic                          Sync
`endif
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    logic sync_w;
`ifdef CLKDIV_PHASE_SYNC_EN
    assign sync_w = Sync;
`else
    assign sync_w = 1'b0;
`endif

    // Out-of-range WrCh matches no instance, so such writes are dropped.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic load_w;
            assign load_w = WrEn && (WrCh == CH_W'(gi));

            clock_divider_ch #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .Clock     (Clock),
                .Reset     (Reset),
                .load_i    (load_w),
                .wr_data_i (WrData),
                .sync_i    (sync_w),
                .div_clk_o (DividedClock[gi]),
                .tick_o    (Tick[gi])
            );
        end
    endgenerate
endmodule
